// File: rtl/uart_ctrl_fifo.sv
// UART control/status block: bus register file, TX/RX FIFOs, sticky flags and interrupt request.
module uart_ctrl_fifo #(
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH),
  parameter int DW        = 9,
  parameter int CKDIV_RST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [11:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_rdata,
  output logic          ena,
  output logic [23:0]   ckdiv,
  output logic          data9b,
  output logic          stop2b,
  output logic [7:0]    totime,
  input  logic          error,
  input  logic          txbusy,
  input  logic          timeout,
  input  logic          tx_pop,
  output logic [DW-1:0] tx_byte,
  output logic          tx_empty,
  input  logic          rx_push,
  input  logic [DW-1:0] rx_byte,
  output logic          int_req
);

  localparam logic [23:0] CKDIV_MIN = 24'(CKDIV_RST);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic          ready_q, rd_pend_q;
  logic [4:0]    ie_q;
  logic [AW:0]   txthr_q, rxthr_q;
  logic          if_rxtout_q, if_rxovf_q, if_txovf_q;
  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [AW:0]   tx_level, rx_level;
  logic [31:0]   rd_word;

  logic commit, is_wr, sel_cr, sel_sr, sel_dr, sel_ck, sel_thr, sel_lvl;
  assign commit  = mem_valid & ready_q;
  assign is_wr   = |mem_wstrb;
  assign sel_cr  = (mem_addr == 12'h000);
  assign sel_sr  = (mem_addr == 12'h004);
  assign sel_dr  = (mem_addr == 12'h008);
  assign sel_ck  = (mem_addr == 12'h00C);
  assign sel_thr = (mem_addr == 12'h010);
  assign sel_lvl = (mem_addr == 12'h014);

  logic tx_full, rx_full, rx_empty;
  assign tx_full  = (tx_level == FULL_LVL);
  assign rx_full  = (rx_level == FULL_LVL);
  assign tx_empty = (tx_level == '0);
  assign rx_empty = (rx_level == '0);
  assign tx_byte  = tx_mem[tx_rptr];

  // Effective FIFO operations; a full FIFO still accepts when it is popped in the same cycle.
  logic dr_wr, tx_pop_eff, tx_push_eff, rx_pop_eff, rx_push_eff, tx_ovf_set, rx_ovf_set;
  assign dr_wr       = ena & commit & is_wr & sel_dr;
  assign tx_pop_eff  = ena & tx_pop & ~tx_empty;
  assign tx_push_eff = dr_wr & (~tx_full | tx_pop_eff);
  assign tx_ovf_set  = dr_wr & tx_full & ~tx_pop_eff;
  assign rx_pop_eff  = ena & commit & ~is_wr & sel_dr & rd_pend_q;
  assign rx_push_eff = ena & rx_push & (~rx_full | rx_pop_eff);
  assign rx_ovf_set  = ena & rx_push & rx_full & ~rx_pop_eff;

  logic if_txthr, if_rxthr;
  logic [AW:0] rxthr_eff;
  logic [4:0]  if_vec;
  assign rxthr_eff = (rxthr_q == '0) ? LVL_ONE : rxthr_q;
  assign if_txthr  = (tx_level <= txthr_q);
  assign if_rxthr  = (rx_level >= rxthr_eff);
  assign if_vec    = {if_txovf_q, if_rxovf_q, if_rxtout_q, if_rxthr, if_txthr};
  assign int_req   = |(ie_q & if_vec);
  assign mem_ready = ready_q;

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:24];

  // Read data multiplexer for the register map.
  always_comb begin
    rd_word = '0;
    if (sel_cr) begin
      rd_word[0]     = ena;
      rd_word[1]     = data9b;
      rd_word[2]     = stop2b;
      rd_word[15:8]  = totime;
      rd_word[20:16] = ie_q;
    end else if (sel_sr) begin
      rd_word[0]     = error;
      rd_word[1]     = txbusy;
      rd_word[2]     = tx_full;
      rd_word[3]     = rx_empty;
      rd_word[20:16] = if_vec;
    end else if (sel_dr) begin
      rd_word = rx_empty ? '0 : 32'(rx_mem[rx_rptr]);
    end else if (sel_ck) begin
      rd_word[23:0] = ckdiv;
    end else if (sel_thr) begin
      rd_word[AW:0]       = txthr_q;
      rd_word[AW+16:16]   = rxthr_q;
    end else if (sel_lvl) begin
      rd_word[AW:0]       = tx_level;
      rd_word[AW+16:16]   = rx_level;
    end
  end

  // Bus handshake: one-cycle ready pulse, read data captured in the request cycle.
  // The DR pop decision is frozen at capture so a byte arriving mid-handshake is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      mem_rdata <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      ready_q <= mem_valid & ~ready_q;
      if (mem_valid & ~ready_q) begin
        mem_rdata <= is_wr ? '0 : rd_word;
        rd_pend_q <= ~is_wr & sel_dr & ~rx_empty;
      end
    end
  end

  // Configuration registers (CR, CKDIV, THR); retained across ena=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena     <= 1'b0;
      data9b  <= 1'b0;
      stop2b  <= 1'b0;
      totime  <= '0;
      ie_q    <= '0;
      ckdiv   <= CKDIV_MIN;
      txthr_q <= '0;
      rxthr_q <= '0;
    end else if (commit & is_wr) begin
      if (sel_cr) begin
        ena    <= mem_wdata[0];
        data9b <= mem_wdata[1];
        stop2b <= mem_wdata[2];
        totime <= mem_wdata[15:8];
        ie_q   <= mem_wdata[20:16];
      end
      if (sel_ck) ckdiv <= (mem_wdata[23:0] < CKDIV_MIN) ? CKDIV_MIN : mem_wdata[23:0];
      if (sel_thr) begin
        txthr_q <= mem_wdata[AW:0];
        rxthr_q <= mem_wdata[AW+16:16];
      end
    end
  end

  // Sticky flags: W1C clear first, then sets so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rxtout_q <= 1'b0;
      if_rxovf_q  <= 1'b0;
      if_txovf_q  <= 1'b0;
    end else if (!ena) begin
      if_rxtout_q <= 1'b0;
      if_rxovf_q  <= 1'b0;
      if_txovf_q  <= 1'b0;
    end else begin
      if (commit & is_wr & sel_sr) begin
        if (mem_wdata[18]) if_rxtout_q <= 1'b0;
        if (mem_wdata[19]) if_rxovf_q  <= 1'b0;
        if (mem_wdata[20]) if_txovf_q  <= 1'b0;
      end
      if (timeout)    if_rxtout_q <= 1'b1;
      if (rx_ovf_set) if_rxovf_q  <= 1'b1;
      if (tx_ovf_set) if_txovf_q  <= 1'b1;
    end
  end

  // FIFO pointers and levels; ena=0 flushes both FIFOs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0; tx_rptr <= '0; tx_level <= '0;
      rx_wptr <= '0; rx_rptr <= '0; rx_level <= '0;
    end else if (!ena) begin
      tx_wptr <= '0; tx_rptr <= '0; tx_level <= '0;
      rx_wptr <= '0; rx_rptr <= '0; rx_level <= '0;
    end else begin
      if (tx_push_eff) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop_eff)  tx_rptr <= tx_rptr + PTR_ONE;
      if (tx_push_eff & ~tx_pop_eff) tx_level <= tx_level + LVL_ONE;
      else if (~tx_push_eff & tx_pop_eff) tx_level <= tx_level - LVL_ONE;
      if (rx_push_eff) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop_eff)  rx_rptr <= rx_rptr + PTR_ONE;
      if (rx_push_eff & ~rx_pop_eff) rx_level <= rx_level + LVL_ONE;
      else if (~rx_push_eff & rx_pop_eff) rx_level <= rx_level - LVL_ONE;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    if (tx_push_eff) tx_mem[tx_wptr] <= mem_wdata[DW-1:0];
    if (rx_push_eff) rx_mem[rx_wptr] <= rx_byte;
  end

endmodule
